vga_scan_counter: RTL

- Raster timing source for the VGA path.
- Divides the system clock into a pixel tick and runs the horizontal and vertical pixel/line counters.
- Produces the line-end enable pulse and the vertical count consumed by the vertical sync FSM. It also produces the horizontal count consumed by the horizontal sync logic, plus video-active and frame-end flags for the pixel generator.

---
 rtl/vga_scan_counter.sv | 65 ++++++
 1 files changed

// File: rtl/vga_scan_counter.sv
// Raster timing source: a pixel-tick divider feeding cascaded horizontal and
// vertical counters, with line-end, frame-end and video-active decodes.
module vga_scan_counter #(
  parameter int DW       = 10,
  parameter int DIV      = 2,
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clr,
  output logic          pix_tick,
  output logic [DW-1:0] H_conteo,
  output logic [DW-1:0] V_conteo,
  output logic          v_enable,
  output logic          frame_end,
  output logic          video_on
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DW-1:0]    H_LAST   = DW'(H_TOTAL - 1);
  localparam logic [DW-1:0]    V_LAST   = DW'(V_TOTAL - 1);
  localparam logic [DW-1:0]    H_ACT    = DW'(H_ACTIVE);
  localparam logic [DW-1:0]    V_ACT    = DW'(V_ACTIVE);

  if (DIV < 1 || (H_TOTAL - 1) >= (1 << DW) || (V_TOTAL - 1) >= (1 << DW) ||
      H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL) begin : g_bad_params
    $error("vga_scan_counter: parameter set does not fit DW or is inconsistent");
  end

  logic [DIV_W-1:0] div_cnt;

  // Pulses decode from registered state so they stay one clk wide for any DIV.
  // NOTE: rst gates pix_tick because with DIV=1 the divider compare is always true.
  assign pix_tick  = enable & ~rst & (div_cnt == DIV_LAST);
  assign v_enable  = pix_tick & (H_conteo == H_LAST);
  assign frame_end = v_enable & (V_conteo == V_LAST);
  assign video_on  = (H_conteo < H_ACT) && (V_conteo < V_ACT);

  // NOTE: all state updates use non-blocking assignments so every counter sees
  // the pre-edge value of the enables feeding it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      H_conteo <= '0;
      V_conteo <= '0;
    end else if (clr) begin
      div_cnt  <= '0;
      H_conteo <= '0;
      V_conteo <= '0;
    end else if (enable) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      if (pix_tick)
        H_conteo <= (H_conteo == H_LAST) ? '0 : H_conteo + DW'(1);
      if (v_enable)
        V_conteo <= (V_conteo == V_LAST) ? '0 : V_conteo + DW'(1);
    end
  end

endmodule
